// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - shares the register-file write port between the MEM/WB pipeline and a long-latency unit
module wb_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 7,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PipeValid,
    input  logic [ADDR_W-1:0] PipeAddr,
    input  logic [DATA_W-1:0] PipeData,
    input  logic              UnitValid,
    input  logic [ADDR_W-1:0] UnitAddr,
    input  logic [DATA_W-1:0] UnitData,
    output logic              UnitReady,
    output logic              StallPipe,
    output logic              WrEn,
    output logic [ADDR_W-1:0] WrAddr,
    output logic [DATA_W-1:0] WrData
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HELD  = 2'd1,
        S_FORCE = 2'd2
    } state_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;

    logic              sel_en;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              unit_ready;
    logic              stall_pipe;
    logic              transfer;
    logic [3:0]        cnt_inc;

    assign transfer = UnitValid && unit_ready;
    assign cnt_inc  = cnt_q + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        sel_en     = 1'b0;
        sel_addr   = PipeAddr;
        sel_data   = PipeData;
        case (state_q)
            S_IDLE: begin
                if (PipeValid) begin
                    sel_en = 1'b1;
                    // A losing result for r0 would be discarded anyway, so never buffer it.
                    if (transfer && (UnitAddr != '0)) begin
                        buf_addr_d = UnitAddr;
                        buf_data_d = UnitData;
                        cnt_d      = 4'd0;
                        state_d    = S_HELD;
                    end
                end else if (transfer) begin
                    sel_en   = 1'b1;
                    sel_addr = UnitAddr;
                    sel_data = UnitData;
                end
            end
            S_HELD: begin
                sel_en = 1'b1;
                if (!PipeValid) begin
                    sel_addr = buf_addr_q;
                    sel_data = buf_data_q;
                    state_d  = S_IDLE;
                end else if (PipeAddr == buf_addr_q) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = (cnt_q == STARVE_LIM) ? cnt_q : cnt_inc;
                    if (cnt_inc == STARVE_LIM) begin
                        state_d = S_FORCE;
                    end
                end
            end
            S_FORCE: begin
                // Pipeline is frozen this cycle, so its entry is simply replayed later.
                sel_en   = 1'b1;
                sel_addr = buf_addr_q;
                sel_data = buf_data_q;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        unit_ready = 1'b0;
        stall_pipe = 1'b0;
        if (!rst) begin
            unit_ready = (state_q == S_IDLE);
            stall_pipe = (state_q == S_FORCE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= sel_en && (sel_addr != '0);
            if (sel_en && (sel_addr != '0)) begin
                wr_addr_q <= sel_addr;
                wr_data_q <= sel_data;
            end
        end
    end

    assign UnitReady = unit_ready;
    assign StallPipe = stall_pipe;
    assign WrEn      = wr_en_q;
    assign WrAddr    = wr_addr_q;
    assign WrData    = wr_data_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 7;

    logic              clk;
    logic              rst;
    logic              PipeValid;
    logic [ADDR_W-1:0] PipeAddr;
    logic [DATA_W-1:0] PipeData;
    logic              UnitValid;
    logic [ADDR_W-1:0] UnitAddr;
    logic [DATA_W-1:0] UnitData;
    logic              UnitReady;
    logic              StallPipe;
    logic              WrEn;
    logic [ADDR_W-1:0] WrAddr;
    logic [DATA_W-1:0] WrData;

    int total = 0;
    int bad   = 0;

    wb_port_arbiter #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .STARVE_MAX(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .PipeValid(PipeValid),
        .PipeAddr (PipeAddr),
        .PipeData (PipeData),
        .UnitValid(UnitValid),
        .UnitAddr (UnitAddr),
        .UnitData (UnitData),
        .UnitReady(UnitReady),
        .StallPipe(StallPipe),
        .WrEn     (WrEn),
        .WrAddr   (WrAddr),
        .WrData   (WrData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input logic en, input int addr, input int data);
        check({tag, ".en"}, 64'(WrEn), 64'(en));
        check({tag, ".addr"}, 64'(WrAddr), 64'(addr));
        check({tag, ".data"}, 64'(WrData), 64'(data));
    endtask

    task automatic chk_ctl(input string tag, input logic rdy, input logic stall);
        check({tag, ".rdy"}, 64'(UnitReady), 64'(rdy));
        check({tag, ".stall"}, 64'(StallPipe), 64'(stall));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic v, input int a, input int d);
        PipeValid = v;
        PipeAddr  = ADDR_W'(a);
        PipeData  = DATA_W'(d);
    endtask

    task automatic unit(input logic v, input int a, input int d);
        UnitValid = v;
        UnitAddr  = ADDR_W'(a);
        UnitData  = DATA_W'(d);
    endtask

    initial begin
        rst = 1'b1;
        pipe(1'b1, 11, 9);
        unit(1'b1, 5, 7);

        // reset with both requesters active
        cyc();
        chk_wr("rst0", 1'b0, 0, 0);
        chk_ctl("rst0", 1'b0, 1'b0);
        cyc();
        chk_wr("rst1", 1'b0, 0, 0);
        chk_ctl("rst1", 1'b0, 1'b0);
        rst = 1'b0;
        pipe(1'b0, 0, 0);
        unit(1'b0, 0, 0);
        #1;
        chk_ctl("rel", 1'b1, 1'b0);
        check("rel.en", 64'(WrEn), 64'(0));

        // solo pipe, solo unit
        pipe(1'b1, 11, 9);
        cyc();
        chk_wr("pipe", 1'b1, 11, 9);
        pipe(1'b0, 0, 0);
        unit(1'b1, 5, 7);
        cyc();
        chk_wr("unit", 1'b1, 5, 7);
        chk_ctl("unit", 1'b1, 1'b0);
        unit(1'b0, 0, 0);

        // r0 writes never assert WrEn
        pipe(1'b1, 0, 32'h55);
        cyc();
        chk_wr("p0", 1'b0, 5, 7);
        pipe(1'b0, 0, 0);
        unit(1'b1, 0, 32'h66);
        cyc();
        chk_wr("u0", 1'b0, 5, 7);
        pipe(1'b1, 3, 4);
        unit(1'b1, 0, 32'h77);
        cyc();
        chk_wr("col0", 1'b1, 3, 4);
        chk_ctl("col0", 1'b1, 1'b0);
        pipe(1'b0, 0, 0);
        unit(1'b0, 0, 0);
        cyc();
        chk_wr("col0.after", 1'b0, 3, 4);

        // collision and drain
        pipe(1'b1, 1, 2);
        unit(1'b1, 5, 7);
        cyc();
        chk_wr("col", 1'b1, 1, 2);
        chk_ctl("col", 1'b0, 1'b0);
        pipe(1'b0, 0, 0);
        unit(1'b0, 0, 0);
        cyc();
        chk_wr("drain", 1'b1, 5, 7);
        chk_ctl("drain", 1'b1, 1'b0);
        cyc();
        chk_wr("idle", 1'b0, 5, 7);

        // starvation: four pipe wins, then a one-cycle forced stall
        pipe(1'b1, 1, 2);
        unit(1'b1, 5, 7);
        cyc();
        chk_ctl("st.cap", 1'b0, 1'b0);
        unit(1'b0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            pipe(1'b1, 20 + i, 100 + i);
            cyc();
            chk_wr($sformatf("st%0d", i), 1'b1, 20 + i, 100 + i);
            chk_ctl($sformatf("st%0d", i), 1'b0, (i == 3));
        end
        pipe(1'b1, 24, 124);
        cyc();
        chk_wr("st.force", 1'b1, 5, 7);
        chk_ctl("st.force", 1'b1, 1'b0);
        cyc();
        chk_wr("st.replay", 1'b1, 24, 124);
        pipe(1'b0, 0, 0);
        cyc();
        chk_wr("st.idle", 1'b0, 24, 124);

        // kill: younger pipe write to the buffered address
        pipe(1'b1, 1, 2);
        unit(1'b1, 5, 7);
        cyc();
        unit(1'b0, 0, 0);
        pipe(1'b1, 5, 3);
        cyc();
        chk_wr("kill", 1'b1, 5, 3);
        chk_ctl("kill", 1'b1, 1'b0);
        pipe(1'b0, 0, 0);
        cyc();
        chk_wr("kill.after", 1'b0, 5, 3);

        // reset while a result is buffered
        pipe(1'b1, 1, 2);
        unit(1'b1, 5, 7);
        cyc();
        chk_ctl("mid.held", 1'b0, 1'b0);
        pipe(1'b0, 0, 0);
        unit(1'b0, 0, 0);
        rst = 1'b1;
        cyc();
        chk_wr("mid.rst", 1'b0, 0, 0);
        chk_ctl("mid.rst", 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk_ctl("mid.rel", 1'b1, 1'b0);
        cyc();
        chk_wr("mid.post0", 1'b0, 0, 0);
        cyc();
        chk_wr("mid.post1", 1'b0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
